rr_bus_arbiter: RTL and testbench

- Round-robin arbiter that shares the single on-chip memory/bus port among up to 8 requesters (CPU, VGA fetch, I/O, etc.).
- Issues a one-hot grant and a 3-bit owner index, which drive the bus mux select.
- Enforces a one-cycle bus turnaround between owners.
- Enforces a maximum tenure per owner so no requester can starve the others.
- Sits between the requester blocks and the shared memory port mux.

---
 rtl/rr_bus_arbiter_if.sv | 22 ++
 rtl/rr_bus_arbiter.sv | 101 ++++++++++
 tb/tb_rr_bus_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/rr_bus_arbiter_if.sv
// Request/grant bundle between the requester blocks and the shared-bus round-robin arbiter.
// "release" is a reserved word in SystemVerilog, so the owner's last-cycle strobe is named bus_release.
interface rr_bus_arbiter_if #(
  parameter int N_REQ = 8
);
  logic [N_REQ-1:0]         req;
  logic                     bus_release;
  logic [N_REQ-1:0]         gnt;
  logic                     gnt_valid;
  logic [$clog2(N_REQ)-1:0] gnt_id;
  logic                     timeout;

  modport master (
    output req, bus_release,
    input  gnt, gnt_valid, gnt_id, timeout
  );

  modport slave (
    input  req, bus_release,
    output gnt, gnt_valid, gnt_id, timeout
  );
endinterface

// File: rtl/rr_bus_arbiter.sv
// Round-robin owner selection for the shared memory port: registered one-hot grant,
// one dead turnaround cycle between owners, and a MAX_HOLD cap on each tenure.
module rr_bus_arbiter #(
  parameter int N_REQ    = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  rr_bus_arbiter_if.slave  bus
);
  localparam int         ID_W     = $clog2(N_REQ);
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t           state;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  gnt_id_r;
  logic [ID_W-1:0]  win_id;
  logic [7:0]       hold_cnt;
  logic [N_REQ-1:0] gnt_r;
  logic             gnt_valid_r;
  logic             timeout_r;
  logic             win_found;
  logic             owner_req;
  logic             at_limit;
  logic             tenure_end;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v >= HOLD_LIM) ? HOLD_LIM : v + 8'd1;
  endfunction

  // Scan from the farthest offset down so the entry nearest ptr is the one kept.
  // The previous owner sits at ptr-1 after a tenure, so it naturally ranks last.
  always_comb begin
    win_found = 1'b0;
    win_id    = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.req[ptr + ID_W'(k)]) begin
        win_found = 1'b1;
        win_id    = ptr + ID_W'(k);
      end
    end
  end

  assign owner_req  = bus.req[gnt_id_r];
  assign at_limit   = (hold_cnt == HOLD_LIM);
  assign tenure_end = bus.bus_release || !owner_req || at_limit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      gnt_id_r    <= '0;
      hold_cnt    <= '0;
      gnt_r       <= '0;
      gnt_valid_r <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      timeout_r <= 1'b0;
      case (state)
        IDLE, TURN: begin
          if (win_found) begin
            state       <= GRANT;
            gnt_r       <= N_REQ'(1) << win_id;
            gnt_id_r    <= win_id;
            gnt_valid_r <= 1'b1;
            hold_cnt    <= 8'd1;
          end else begin
            state       <= IDLE;
            gnt_r       <= '0;
            gnt_valid_r <= 1'b0;
          end
        end
        GRANT: begin
          if (tenure_end) begin
            state       <= TURN;
            gnt_r       <= '0;
            gnt_valid_r <= 1'b0;
            hold_cnt    <= '0;
            ptr         <= gnt_id_r + ID_W'(1);
            // A voluntary release or dropped request outranks the hold limit.
            timeout_r   <= at_limit && !bus.bus_release && owner_req;
          end else begin
            hold_cnt    <= sat_inc(hold_cnt);
          end
        end
        default: begin
          state       <= IDLE;
          gnt_r       <= '0;
          gnt_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.gnt_valid = gnt_valid_r;
  assign bus.gnt_id    = gnt_id_r;
  assign bus.timeout   = timeout_r;
endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed bench for rr_bus_arbiter: hold limit, rotation, wrap, release/limit priority,
// request drop and reset during a grant, each with hand-worked expected values.
module tb_rr_bus_arbiter;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  rr_bus_arbiter_if #(.N_REQ(8)) bus ();

  rr_bus_arbiter #(.N_REQ(8), .MAX_HOLD(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    bus.req         = '0;
    bus.bus_release = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst             = 1'b1;
    bus.req         = '0;
    bus.bus_release = 1'b0;

    // Reset state
    do_reset();
    check("rst_gnt",       32'(bus.gnt),       32'h00);
    check("rst_gnt_valid", 32'(bus.gnt_valid), 32'd0);
    check("rst_gnt_id",    32'(bus.gnt_id),    32'd0);
    check("rst_timeout",   32'(bus.timeout),   32'd0);

    // Idle with no requests, release outside GRANT ignored
    bus.bus_release = 1'b1;
    tick();
    check("idle_gnt", 32'(bus.gnt), 32'h00);
    bus.bus_release = 1'b0;

    // 1: single requester held, hold limit forces a turnaround
    bus.req = 8'h04;
    tick();
    check("t1_gnt_first",   32'(bus.gnt),       32'h04);
    check("t1_id_first",    32'(bus.gnt_id),    32'd2);
    check("t1_valid_first", 32'(bus.gnt_valid), 32'd1);
    for (int c = 2; c <= 16; c++) begin
      tick();
      check($sformatf("t1_hold_c%0d", c), 32'(bus.gnt), 32'h04);
      check($sformatf("t1_to_c%0d", c), 32'(bus.timeout), 32'd0);
    end
    tick();
    check("t1_turn_gnt",   32'(bus.gnt),       32'h00);
    check("t1_turn_valid", 32'(bus.gnt_valid), 32'd0);
    check("t1_turn_to",    32'(bus.timeout),   32'd1);
    check("t1_turn_id",    32'(bus.gnt_id),    32'd2);
    tick();
    check("t1_regrant", 32'(bus.gnt),     32'h04);
    check("t1_to_off",  32'(bus.timeout), 32'd0);

    // 2: all requesting, release on each first grant cycle, order 0..7 then 0
    do_reset();
    bus.req = 8'hFF;
    tick();
    for (int i = 0; i <= 8; i++) begin
      check($sformatf("t2_gnt_%0d", i), 32'(bus.gnt), 32'(8'h01 << (i % 8)));
      check($sformatf("t2_id_%0d", i), 32'(bus.gnt_id), 32'(i % 8));
      bus.bus_release = 1'b1;
      tick();
      bus.bus_release = 1'b0;
      check($sformatf("t2_dead_%0d", i), 32'(bus.gnt), 32'h00);
      check($sformatf("t2_to_%0d", i), 32'(bus.timeout), 32'd0);
      tick();
    end

    // 3: req 0 and 7, wrap from 7 back to 0
    do_reset();
    bus.req = 8'h81;
    tick();
    check("t3_gnt0", 32'(bus.gnt), 32'h01);
    bus.bus_release = 1'b1;
    tick();
    bus.bus_release = 1'b0;
    check("t3_dead0", 32'(bus.gnt), 32'h00);
    tick();
    check("t3_gnt7", 32'(bus.gnt),    32'h80);
    check("t3_id7",  32'(bus.gnt_id), 32'd7);
    bus.bus_release = 1'b1;
    tick();
    bus.bus_release = 1'b0;
    check("t3_dead7", 32'(bus.gnt), 32'h00);
    tick();
    check("t3_gnt0_again", 32'(bus.gnt), 32'h01);

    // 4: release on the same edge as the hold limit, no timeout pulse
    do_reset();
    bus.req = 8'h08;
    tick();
    check("t4_gnt3", 32'(bus.gnt), 32'h08);
    for (int c = 2; c <= 16; c++) tick();
    check("t4_at_limit", 32'(bus.gnt), 32'h08);
    bus.bus_release = 1'b1;
    tick();
    bus.bus_release = 1'b0;
    check("t4_gnt_off", 32'(bus.gnt),     32'h00);
    check("t4_no_to",   32'(bus.timeout), 32'd0);

    // 5: owner 5 drops its request in cycle 4; requester 6 waits through one dead cycle
    do_reset();
    bus.req = 8'h60;
    tick();
    check("t5_gnt5", 32'(bus.gnt), 32'h20);
    tick();
    tick();
    tick();
    check("t5_cycle4", 32'(bus.gnt), 32'h20);
    bus.req = 8'h40;
    tick();
    check("t5_gnt_off", 32'(bus.gnt),     32'h00);
    check("t5_no_to",   32'(bus.timeout), 32'd0);
    tick();
    check("t5_gnt6", 32'(bus.gnt),    32'h40);
    check("t5_id6",  32'(bus.gnt_id), 32'd6);

    // 6: reset during a grant drops it immediately
    do_reset();
    bus.req = 8'h10;
    tick();
    tick();
    check("t6_gnt4", 32'(bus.gnt), 32'h10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_gnt",   32'(bus.gnt),       32'h00);
    check("t6_rst_valid", 32'(bus.gnt_valid), 32'd0);
    check("t6_rst_id",    32'(bus.gnt_id),    32'd0);
    check("t6_rst_to",    32'(bus.timeout),   32'd0);
    tick();
    check("t6_regrant", 32'(bus.gnt),    32'h10);
    check("t6_id4",     32'(bus.gnt_id), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
